// File: rtl/im_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : im_loader_if
// Purpose  : Bundles the instruction-stream handshake and the instruction
//            memory write port used by im_loader.
// Ports    : in_data/in_valid/in_ready - incoming instruction stream
//            wr_en/wr_addr/wr_data     - instruction memory write port
// Modports : slave  - the loader (consumes the stream, drives the memory port)
//            master - the stream source / memory side
// Revision : 1.0 - initial release
// ============================================================================
interface im_loader_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Purpose  : Loads MEMORY_DEPTH instruction words from a valid/ready stream
//            into instruction memory and holds the CPU until the load is
//            complete. Optional checksum byte after the last word.
// Ports    : clk, rst_n (async, active low), start (session pulse)
//            bus       - im_loader_if.slave (stream in, memory write out)
//            cpu_hold  - CPU halted while memory is not validly loaded
//            load_done - session complete
//            load_err  - checksum mismatch (constant 0 without checksum)
// Config   : define LOADER_CHECKSUM_EN to enable the CHECK state and the
//            8-bit modulo-256 checksum of the loaded words.
// Revision : 1.0 - initial release
// ============================================================================
module im_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5,
  parameter int MEMORY_DEPTH  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  im_loader_if.slave bus,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic                     in_ready_q, in_ready_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     load_done_q, load_done_d;
  logic                     cpu_hold_q, cpu_hold_d;
  logic                     xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
  logic [7:0] in_byte;

  // The checksum is defined over bytes; wider words contribute their low byte.
  assign in_byte = 8'(bus.in_data);
`endif

  // in_ready is registered, so a transfer is only possible in LOAD/CHECK.
  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_byte;
`endif
          // The index stops at the last address instead of wrapping.
          if (idx_q == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + ADDRESS_WIDTH'(1);
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        // The checksum byte is compared only, never written to memory.
        if (xfer) begin
          err_d   = (in_byte != sum_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
`ifdef LOADER_CHECKSUM_EN
    in_ready_d = (state_d == LOAD) || (state_d == CHECK);
    cpu_hold_d = (state_d != DONE) || err_d;
`else
    in_ready_d = (state_d == LOAD);
    cpu_hold_d = (state_d != DONE);
`endif
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
      cpu_hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      load_done_q <= load_done_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign load_done    = load_done_q;
  assign cpu_hold     = cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
  assign load_err     = err_q;
`else
  assign load_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, instruction word width.
REQ-002 The module SHALL have parameter ADDRESS_WIDTH, default 5, instruction memory address width.
REQ-003 The module SHALL have parameter MEMORY_DEPTH, default 32, number of words loaded per session.
REQ-004 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port start  input  1  single-cycle pulse that begins a load session.
REQ-007 The module SHALL have port in_data  input  DATA_WIDTH  incoming instruction byte.
REQ-008 The module SHALL have port in_valid  input  1  in_data valid.
REQ-009 The module SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-010 The module SHALL have port wr_en  output  1  instruction memory write strobe.
REQ-011 The module SHALL have port wr_addr  output  ADDRESS_WIDTH  instruction memory write address.
REQ-012 The module SHALL have port wr_data  output  DATA_WIDTH  instruction memory write data.
REQ-013 The module SHALL have port cpu_hold  output  1  holds the CPU halted while memory is not validly loaded.
REQ-014 The module SHALL have port load_done  output  1  load session complete.
REQ-015 The module SHALL have port load_err  output  1  checksum mismatch; tied 0 when the checksum feature is absent.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, CHECK, DONE; CHECK SHALL exist only with LOADER_CHECKSUM_EN.
REQ-017 In IDLE or DONE, start=1 SHALL move the FSM to LOAD, clear the word index to 0, clear load_done and load_err, and assert cpu_hold.
REQ-018 start SHALL be ignored in LOAD and CHECK.
REQ-019 in_ready SHALL be 1 only in LOAD and CHECK, and SHALL be a registered function of state.
REQ-020 A transfer SHALL occur in a cycle with in_valid=1 and in_ready=1; no other cycle SHALL consume in_data.
REQ-021 Each LOAD transfer SHALL produce, in the next cycle, wr_en=1 for exactly one cycle, with wr_addr equal to the word index and wr_data equal to the accepted in_data (latency 1).
REQ-022 The word index SHALL increment by 1 per LOAD transfer; in_valid=0 cycles SHALL stall without writes.
REQ-023 The transfer at index MEMORY_DEPTH-1 SHALL end LOAD: the FSM SHALL go to CHECK with LOADER_CHECKSUM_EN, else to DONE; the index SHALL NOT wrap into further writes.
REQ-024 wr_en SHALL be 0 in IDLE, CHECK and DONE, except for the last write, which completes in the first cycle after leaving LOAD.
REQ-025 In DONE, load_done SHALL be 1 and cpu_hold SHALL equal load_err.
REQ-026 wr_addr and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE with index 0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, load_done=0, load_err=0 and cpu_hold=1.
REQ-028 Reset asserted mid-session SHALL abort the session immediately with no further writes; memory contents already written SHALL be treated as invalid.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined, the module SHALL keep an 8-bit sum modulo 256 of all accepted LOAD words, cleared at start.
REQ-030 In CHECK, the next transfer SHALL be compared with the sum: on match load_err=0, on mismatch load_err=1, and the FSM SHALL then go to DONE; that byte SHALL NOT be written to memory.
REQ-031 Without LOADER_CHECKSUM_EN, the CHECK state and the sum logic SHALL be absent, load_err SHALL be constant 0, and DONE SHALL follow the last LOAD transfer directly.

Verification
REQ-032 Reset then start, 32 back-to-back words 0x00..0x1F -> wr_en pulses at addresses 0..31 with data equal to address, each one cycle after acceptance; load_done=1; cpu_hold=0 (checksum byte 0xF0 when enabled).
REQ-033 Same stream with in_valid low every other cycle -> exactly 32 writes, no write in stall cycles, same final state.
REQ-034 With LOADER_CHECKSUM_EN, 32 words of 0x01 then checksum 0x21 -> load_err=1, load_done=1, cpu_hold=1, no write of 0x21.
REQ-035 rst_n pulsed low after 10 transfers -> outputs immediately at reset values, no further wr_en; a new start reloads from address 0.
REQ-036 start pulsed at word 5 of LOAD -> ignored, index continues at 6; start in DONE -> new session, load_done cleared next cycle.
